// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer
// Captures one 128-bit trace entry per retired instruction and buffers it in
// a FIFO that a debug consumer drains through a valid/ready port.
//
// An instruction counts as retired when the instruction word changes. The
// entry recorded holds the values from the last cycle of the instruction that
// just finished: {instr, rf_a, rf_b, mem}.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_i      processor instruction word
//   rf_a_i       processor register-file read port A
//   rf_b_i       processor register-file read port B
//   mem_i        processor memory read data
//   cap_en_i     capture enable
//   clear_i      synchronous flush of the FIFO and all status
//   rd_ready_i   consumer accepts the head entry
//   rd_valid_o   FIFO is non-empty
//   rd_data_o    head entry, show-ahead {instr, rf_a, rf_b, mem}
//   count_o      occupancy, 0..DEPTH
//   overflow_o   sticky: at least one entry was dropped
//   drop_cnt_o   number of dropped entries, saturating
module proc_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       rf_a_i,
  input  logic [31:0]       rf_b_i,
  input  logic [31:0]       mem_i,
  input  logic              cap_en_i,
  input  logic              clear_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [127:0]      rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic [15:0]       drop_cnt_o
);

  // Shadow copies of the observation inputs: after any edge they hold the
  // values of the cycle just finished.
  logic [31:0] instr_q, a_q, b_q, m_q;

  logic              primed_q, primed_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [127:0]      mem_q [DEPTH];

  logic empty, full, capture, push, pop, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // primed keeps the first enabled edge from comparing against shadow
  // contents that were loaded while capture was off.
  assign capture = cap_en_i && primed_q && (instr_i != instr_q);
  assign push    = capture && !clear_i;
  assign pop     = !empty && rd_ready_i && !clear_i;
  // A push into a full FIFO is still accepted when the head leaves at the
  // same edge, since a slot frees up.
  assign wr_en   = push && (!full || pop);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // this block leaves one unassigned, which would infer a latch.
    primed_d   = cap_en_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (clear_i) begin
      primed_d   = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push && !wr_en) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      instr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      primed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      instr_q    <= instr_i;
      a_q        <= rf_a_i;
      b_q        <= rf_b_i;
      m_q        <= mem_i;
      primed_q   <= primed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through rd_data_o while rd_valid_o is high, and an unreset array maps
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {instr_q, a_q, b_q, m_q};
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  // Pointer difference is taken modulo 2*DEPTH, so it reads 0..DEPTH and
  // changes only at the edge that moves a pointer.
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Testbench for proc_trace_buffer: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_proc_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       instr_i, rf_a_i, rf_b_i, mem_i;
  logic              cap_en_i, clear_i, rd_ready_i;
  logic              rd_valid_o;
  logic [127:0]      rd_data_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic [15:0]       drop_cnt_o;

  proc_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_i    (instr_i),
    .rf_a_i     (rf_a_i),
    .rf_b_i     (rf_b_i),
    .mem_i      (mem_i),
    .cap_en_i   (cap_en_i),
    .clear_i    (clear_i),
    .rd_ready_i (rd_ready_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: previous-cycle observation values, an enable history
  // bit, a queue of pending entries and the status counters.
  logic [127:0] m_q[$];
  logic [31:0]  m_prev_instr, m_prev_a, m_prev_b, m_prev_m;
  bit           m_was_enabled;
  bit           m_ovf;
  int           m_drops;
  logic [31:0]  uniq = 32'h1000_0000;

  task automatic model_reset();
    m_q.delete();
    m_prev_instr = 0; m_prev_a = 0; m_prev_b = 0; m_prev_m = 0;
    m_was_enabled = 0; m_ovf = 0; m_drops = 0;
  endtask

  // Apply the retire/FIFO rules for the edge about to happen.
  task automatic model_edge();
    bit retire, pop;
    int occ;
    retire = cap_en_i && m_was_enabled && (instr_i != m_prev_instr);
    occ    = m_q.size();
    pop    = (occ > 0) && rd_ready_i;
    if (clear_i) begin
      m_q.delete();
      m_ovf = 0; m_drops = 0; m_was_enabled = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (retire) begin
        if (occ < DEPTH || pop) m_q.push_back({m_prev_instr, m_prev_a, m_prev_b, m_prev_m});
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      m_was_enabled = cap_en_i;
    end
    m_prev_instr = instr_i; m_prev_a = rf_a_i; m_prev_b = rf_b_i; m_prev_m = mem_i;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 128'(rd_valid_o), 128'(m_q.size() != 0));
    check({tag, ".count"}, 128'(count_o), 128'(m_q.size()));
    check({tag, ".ovf"},   128'(overflow_o), 128'(m_ovf));
    check({tag, ".drops"}, 128'(drop_cnt_o), 128'(m_drops));
    if (m_q.size() != 0) check({tag, ".data"}, rd_data_o, m_q[0]);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_obs(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] m);
    instr_i = ins; rf_a_i = a; rf_b_i = b; mem_i = m;
  endtask

  // Present a fresh instruction word with random operands for n cycles.
  task automatic new_instr(input int n, input string tag);
    uniq = uniq + 1;
    set_obs(uniq, $urandom, $urandom, $urandom);
    repeat (n) step(tag);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step("clear");
    clear_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_obs(0, 0, 0, 0);
    cap_en_i = 0; clear_i = 0; rd_ready_i = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset/prime: held word, then a change produces exactly one entry.
    cap_en_i = 1'b1;
    set_obs(32'h2002_0005, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
    repeat (3) step("prime");
    check("prime.empty", 128'(rd_valid_o), 128'(0));
    set_obs(32'h2003_0007, 32'h1, 32'h2, 32'h3);
    step("prime.cap");
    check("prime.entry", rd_data_o,
          {32'h2002_0005, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003});
    check("prime.cnt1", 128'(count_o), 128'(1));
    step("prime.hold");

    // Sequence capture: five instructions, four cycles each.
    do_clear();
    for (int i = 0; i < 5; i++) begin
      set_obs(32'h3000_0000 + i, i, i + 100, i + 200);
      repeat (4) step("seq");
    end
    check("seq.cnt4", 128'(count_o), 128'(4));
    check("seq.head", rd_data_o, {32'h3000_0000, 32'd0, 32'd100, 32'd200});
    rd_ready_i = 1'b1;
    repeat (5) step("seq.drain");
    rd_ready_i = 1'b0;

    // Overflow: DEPTH+3 completed instructions with no reads.
    do_clear();
    set_obs(32'h4000_0000, 0, 0, 0);
    step("ovf.prime");
    for (int i = 1; i <= DEPTH + 3; i++) begin
      set_obs(32'h4000_0000 + i, i, 0, 0);
      step("ovf");
    end
    check("ovf.cnt", 128'(count_o), 128'(DEPTH));
    check("ovf.flag", 128'(overflow_o), 128'(1));
    check("ovf.drops", 128'(drop_cnt_o), 128'(3));
    check("ovf.head", rd_data_o[127:96], 128'(32'h4000_0000));

    // Full with simultaneous push and pop.
    do_clear();
    new_instr(1, "full.prime");
    for (int i = 0; i < DEPTH; i++) new_instr(1, "full.fill");
    check("full.cnt", 128'(count_o), 128'(DEPTH));
    rd_ready_i = 1'b1;
    new_instr(1, "full.pushpop");
    rd_ready_i = 1'b0;
    check("full.cnt_kept", 128'(count_o), 128'(DEPTH));
    check("full.no_ovf", 128'(overflow_o), 128'(0));

    // Clear priority with count=7 and overflow set.
    new_instr(1, "clr.drop");
    rd_ready_i = 1'b1;
    repeat (DEPTH - 7) step("clr.drain");
    rd_ready_i = 1'b0;
    check("clr.pre_cnt", 128'(count_o), 128'(7));
    check("clr.pre_ovf", 128'(overflow_o), 128'(1));
    rd_ready_i = 1'b1; clear_i = 1'b1;
    uniq = uniq + 1;
    instr_i = uniq;
    step("clr.edge");
    clear_i = 1'b0; rd_ready_i = 1'b0;
    check("clr.cnt", 128'(count_o), 128'(0));
    check("clr.ovf", 128'(overflow_o), 128'(0));
    check("clr.valid", 128'(rd_valid_o), 128'(0));
    new_instr(1, "clr.reprime");
    new_instr(1, "clr.recap");
    check("clr.recap_cnt", 128'(count_o), 128'(1));

    // Async reset mid-drain.
    do_clear();
    new_instr(1, "ar.prime");
    for (int i = 0; i < 5; i++) new_instr(1, "ar.fill");
    check("ar.cnt5", 128'(count_o), 128'(5));
    rd_ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar.valid", 128'(rd_valid_o), 128'(0));
    check("ar.cnt", 128'(count_o), 128'(0));
    check_outputs("ar.all");
    @(negedge clk);
    rst_n = 1'b1;
    rd_ready_i = 1'b0;
    step("ar.after");

    // Randomized traffic in phases with different read pressure.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          uniq = uniq + 1;
          instr_i = uniq;
        end
        rf_a_i = $urandom; rf_b_i = $urandom; mem_i = $urandom;
        cap_en_i   = ($urandom_range(0, 19) != 0);
        clear_i    = ($urandom_range(0, 99) == 0);
        rd_ready_i = ($urandom_range(0, 9) < (ph % 3) * 4);
        step("rand");
      end
    end
    clear_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always ends even if time stops advancing usefully.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
